jk_excitation_driver: RTL and testbench

- Initiator side of the JK flip-flop interface: drives i_j/i_k of a flipflop_jk instance so that its o_q follows a requested bit pattern.
- Takes its clock from the same i_clk as the flip-flop.
- Accepts a WIDTH-bit target pattern over a valid/ready handshake and plays it out LSB-first, one bit per clock.
- Checks the flip-flop's o_q, fed back on i_q, and reports completion and mismatches.
- Used as a reusable stimulus/checker for JK-based counters and registers.

---
 rtl/jk_excitation_driver.sv | 102 ++++++++++
 tb/tb_jk_excitation_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Drives J/K of a JK flip-flop so its Q plays a WIDTH-bit pattern LSB-first, and checks Q via feedback.
// Optional mismatch counter output o_err_count under `JK_EXCITATION_DRIVER_ERRCNT_EN.
module jk_excitation_driver #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_pattern,
  output logic             o_ready,
  input  logic             i_q,
  output logic             o_j,
  output logic             o_k,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
`ifdef JK_EXCITATION_DRIVER_ERRCNT_EN
  ,
  output logic [7:0]       o_err_count
`endif
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] pat;
  logic             err_q, done_q;
  logic             accept, last, t, exp_q, cmp_en, mism;

  assign accept = i_valid && (state == IDLE);
  assign last   = (idx == IW'(WIDTH - 1));
  assign t      = pat[idx];
  // Q lags the excitation by one edge, so compare against the previous bit.
  assign exp_q  = (state == CHECK) ? pat[WIDTH-1] : pat[idx - IW'(1)];
  assign cmp_en = ((state == DRIVE) && (idx != '0)) || (state == CHECK);
  assign mism   = cmp_en && (i_q != exp_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = DRIVE;
      DRIVE:   if (last)   state_nx = CHECK;
      CHECK:               state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_busy  = (state == DRIVE) || (state == CHECK);
    o_j     = 1'b0;
    o_k     = 1'b0;
    if (state == DRIVE) begin
      if (idx == '0) begin
        // Direct set/reset gives a known Q regardless of prior (or X) state.
        o_j = t;
        o_k = ~t;
      end else if (i_q != t) begin
        o_j = 1'b1;
        o_k = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx    <= '0;
      pat    <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == CHECK);
      if (accept) begin
        pat   <= i_pattern;
        idx   <= '0;
        err_q <= 1'b0;
      end else begin
        if ((state == DRIVE) && !last) idx <= idx + IW'(1);
        if (mism) err_q <= 1'b1;
      end
    end
  end

  assign o_done = done_q;
  assign o_err  = err_q;

`ifdef JK_EXCITATION_DRIVER_ERRCNT_EN
  logic [7:0] err_cnt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                       err_cnt <= '0;
    else if (mism && err_cnt != '1)  err_cnt <= err_cnt + 8'd1;
  end
  assign o_err_count = err_cnt;
`endif
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: closes the loop through a behavioural JK flip-flop, or ties Q low for fault cases.
// Exercises o_err_count when JK_EXCITATION_DRIVER_ERRCNT_EN is defined.
module tb_jk_excitation_driver;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_pattern = '0;
  logic       o_ready, i_q, o_j, o_k, o_busy, o_done, o_err;
`ifdef JK_EXCITATION_DRIVER_ERRCNT_EN
  logic [7:0] o_err_count;
`endif

  logic        ff_q = 1'b0;
  logic        tie0 = 1'b0;
  logic [15:0] jk_log;
  logic [7:0]  q_log;
  int          checks = 0;
  int          failures = 0;
  int          lat;
  logic        seen_done;

  always #5 i_clk = ~i_clk;

  // Behavioural JK flip-flop on the same clock.
  always_ff @(posedge i_clk) begin
    case ({o_j, o_k})
      2'b01:   ff_q <= 1'b0;
      2'b10:   ff_q <= 1'b1;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase
  end
  assign i_q = tie0 ? 1'b0 : ff_q;

  jk_excitation_driver #(.WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_pattern(i_pattern),
    .o_ready(o_ready), .i_q(i_q), .o_j(o_j), .o_k(o_k), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
`ifdef JK_EXCITATION_DRIVER_ERRCNT_EN
    , .o_err_count(o_err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic start(input logic [7:0] p);
    @(negedge i_clk);
    i_valid   = 1'b1;
    i_pattern = p;
  endtask

  // Cycle 1 is the first DRIVE cycle; returns the cycle index o_done was seen in (0 = timeout).
  task automatic wait_done(input bit hold, input logic [7:0] nxt, output int l);
    l = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (c == 1) begin
        if (hold) i_pattern = nxt;
        else      i_valid   = 1'b0;
      end
      if (c <= 8) jk_log[2*(c-1) +: 2] = {o_j, o_k};
      if (c >= 2 && c <= 9) q_log[c-2] = i_q;
      if (o_done) begin
        l = c;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_outputs", {o_ready, o_busy, o_done, o_err, o_j, o_k}, 6'b100000);
    i_rst = 1'b0;

    // Reset mid-pattern: 3rd DRIVE cycle of A5
    start(8'hA5);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("a5_busy", {o_busy, o_ready}, 2'b10);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_out", {o_j, o_k, o_busy, o_ready}, 4'b0001);
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      seen_done |= o_done;
    end
    i_rst = 1'b0;
    repeat (12) begin
      @(negedge i_clk);
      seen_done |= o_done;
    end
    chk("rst_no_done", seen_done, 1'b0);

    // 00 accepted normally after reset
    start(8'h00);
    wait_done(1'b0, 8'h00, lat);
    chk("p00_lat", lat, 10);
    chk("p00_err", o_err, 1'b0);
    chk("p00_q", q_log, 8'h00);

    // FF from Q=0: set then hold
    start(8'hFF);
    wait_done(1'b0, 8'h00, lat);
    chk("pff_lat", lat, 10);
    chk("pff_jk", jk_log, 16'h0002);
    chk("pff_q", q_log, 8'hFF);
    chk("pff_err", o_err, 1'b0);

    // AA: reset then toggle every cycle
    start(8'hAA);
    wait_done(1'b0, 8'h00, lat);
    chk("paa_lat", lat, 10);
    chk("paa_jk", jk_log, 16'hFFFD);
    chk("paa_q", q_log, 8'hAA);
    chk("paa_err", o_err, 1'b0);

    // Fault: Q stuck low, pattern 0F
    tie0 = 1'b1;
    start(8'h0F);
    wait_done(1'b0, 8'h00, lat);
    chk("p0f_lat", lat, 10);
    chk("p0f_err", o_err, 1'b1);
`ifdef JK_EXCITATION_DRIVER_ERRCNT_EN
    chk("p0f_cnt", o_err_count, 8'd4);
`endif
    @(negedge i_clk);
    chk("p0f_err_hold", {o_err, o_done}, 2'b10);
    tie0 = 1'b0;

    // Handshake: valid held with 33 during busy, taken right after o_done
    start(8'hAA);
    @(negedge i_clk);
    i_pattern = 8'h33;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("hs_not_ready", {o_busy, o_ready}, 2'b10);
    lat = 0;
    for (int c = 4; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_done) begin
        lat = c;
        break;
      end
    end
    chk("hs_first_lat", lat, 10);
    chk("hs_first_err", {o_err, o_ready, i_valid}, 3'b011);
    wait_done(1'b0, 8'h00, lat);
    chk("hs_second_lat", lat, 10);
    chk("hs_second_q", q_log, 8'h33);
    chk("hs_second_err", o_err, 1'b0);

`ifdef JK_EXCITATION_DRIVER_ERRCNT_EN
    // Saturation: 70 x FF with Q stuck low
    tie0 = 1'b1;
    for (int n = 0; n < 70; n++) begin
      start(8'hFF);
      wait_done(1'b0, 8'h00, lat);
    end
    chk("sat_cnt", o_err_count, 8'd255);
    start(8'hFF);
    wait_done(1'b0, 8'h00, lat);
    chk("sat_hold", o_err_count, 8'd255);
    chk("sat_err", o_err, 1'b1);
    tie0 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
